// File: rtl/mdu.sv
// ----------------------------------------------------------------------------
// mdu : multiply/divide unit holding the architectural HI and LO registers.
//
// The 64-bit result of mult/multu/div/divu is computed combinationally from
// the operands present at the accepting edge and parked in pending registers.
// The unit then stays Busy for a fixed number of cycles (MULT_CYCLES or
// DIV_CYCLES) and commits the pending value to HI/LO on the last busy edge.
// mthi/mtlo write HI/LO directly at the accepting edge without going busy.
//
// State table
//   IDLE | waiting for a request; HI/LO may be written by mthi/mtlo
//   RUN  | mult/div in flight; counter counts down, commit when it reaches 1
//
// Ports
//   clk    : clock, all state updates on rising edge
//   reset  : synchronous, active-high
//   A, B   : operands (A also the source for mthi/mtlo)
//   Start  : request qualifier for MDUOp
//   MDUOp  : 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo
//   Busy   : high while a mult/div is in flight
//   HI, LO : architectural HI/LO registers
// ----------------------------------------------------------------------------
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pend_hi, pend_lo;

  logic          accept;
  logic          is_mult, is_div, is_long;
  logic          commit;

  logic [63:0]   prod_s, prod_u;
  logic          div_signed, a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe;
  logic [31:0]   q_mag, r_mag, quot, rem;
  logic [31:0]   res_hi, res_lo;

  assign is_mult = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign is_div  = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);
  assign is_long = is_mult || is_div;
  assign accept  = Start && (state == IDLE) && (MDUOp != 3'b000) && (MDUOp != 3'b111);
  assign commit  = (state == RUN) && (cnt <= CW'(1));

  // Products: sign-extending both operands to 64 bits makes the low 64 bits
  // of the product the two's-complement signed result.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Division runs on magnitudes so 0x80000000 / -1 needs no special case:
  // |A| = 0x80000000 unsigned, quotient stays 0x80000000 after sign fix-up.
  assign div_signed = (MDUOp == OP_DIV);
  assign a_neg      = div_signed && A[31];
  assign b_neg      = div_signed && B[31];
  assign a_mag      = a_neg ? (32'd0 - A) : A;
  assign b_mag      = b_neg ? (32'd0 - B) : B;
  assign b_safe     = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    case (MDUOp)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        // Divide by zero re-commits the current HI/LO, which cannot change
        // while busy, so the architectural registers are left untouched.
        if (B != 32'd0) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && is_long) begin
          state_nxt = RUN;
          cnt_nxt   = is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      RUN: begin
        if (cnt <= CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept && is_long) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
      end
      if (commit) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end else if (accept && (MDUOp == OP_MTHI)) begin
        hi_q <= A;
      end else if (accept && (MDUOp == OP_MTLO)) begin
        lo_q <= A;
      end
    end
  end

  assign Busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
Parameters:
REQ-001 SHALL have parameter MULT_CYCLES, default 5: Busy cycles for mult and multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: Busy cycles for div and divu.
Ports:
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-005 SHALL have port A, input, 32 bits: operand 1 (rs value); dividend or multiplicand; source for mthi and mtlo.
REQ-006 SHALL have port B, input, 32 bits: operand 2 (rt value); divisor or multiplier.
REQ-007 SHALL have port Start, input, 1 bit: one-cycle request qualifier for MDUOp.
REQ-008 SHALL have port MDUOp, input, 3 bits, with these encodings:
- 001 mult
- 010 multu
- 011 div
- 100 divu
- 101 mthi
- 110 mtlo
- 000, 111: no-op.
REQ-009 SHALL have port Busy, output, 1 bit: high while a mult or div is in flight.
REQ-010 SHALL have ports HI and LO, output, 32 bits each: architectural HI and LO registers (mfhi, mflo source).

Function
REQ-011 SHALL treat a request as accepted only when Start=1, Busy=0, and MDUOp is 001-110.
REQ-012 SHALL ignore Start while Busy=1: no state change, no queuing.
REQ-013 SHALL ignore Start with MDUOp 000 or 111.
REQ-014 SHALL contain two states, IDLE and RUN, plus a cycle counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE, an accepted mult, multu, div or divu SHALL:
- latch the computed 64-bit result into pending registers at that edge;
- load the counter with MULT_CYCLES or DIV_CYCLES;
- enter RUN.
REQ-016 SHALL hold Busy=1 from the cycle after acceptance for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 SHALL decrement the counter once per cycle in RUN.
REQ-018 On the last RUN cycle's edge, SHALL commit the pending registers to HI and LO, clear Busy and return to IDLE.
REQ-019 SHALL make new HI and LO visible in the first cycle with Busy=0 after an operation.
REQ-020 SHALL keep HI and LO at their prior values throughout RUN.
REQ-021 SHALL allow a new Start to be accepted in the first cycle after Busy falls (back-to-back operations).
REQ-022 mult SHALL compute the signed 32x32 to 64-bit product, with {HI,LO} = product.
REQ-023 multu SHALL compute the unsigned 32x32 to 64-bit product, with {HI,LO} = product.
REQ-024 div SHALL produce signed results:
- LO = quotient, truncated toward zero;
- HI = remainder, carrying the sign of the dividend A.
REQ-025 divu SHALL produce unsigned results: LO = quotient, HI = remainder.
REQ-026 div with A=0x80000000, B=0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-027 Division with B=0 SHALL still take DIV_CYCLES with Busy=1, and SHALL leave HI and LO unchanged at commit.
REQ-028 mthi SHALL write A to HI at the accepting edge, leave LO unchanged, and SHALL NOT assert Busy.
REQ-029 mtlo SHALL write A to LO at the accepting edge, leave HI unchanged, and SHALL NOT assert Busy.
REQ-030 SHALL compute results only from A and B sampled at the accepting edge; later changes to A and B during RUN SHALL have no effect.
REQ-031 SHALL drive HI, LO and Busy directly from registers, with no combinational path from any input.
REQ-032 The pipeline stall condition (Start with a mult or div op, or Busy) is formed outside this block; the block SHALL NOT stall anything itself.

Reset
REQ-033 When reset=1 at a rising edge, the block SHALL set HI=0, LO=0, Busy=0, counter=0, pending registers=0 and state=IDLE.
REQ-034 Reset SHALL take priority over Start in the same cycle.
REQ-035 Reset during RUN SHALL abort the operation, with no commit.
REQ-036 SHALL accept the first Start in the cycle after reset is deasserted.

Verification
REQ-037 A bench SHALL cover: mult A=0xFFFFFFFF, B=2 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; repeat as multu -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-038 A bench SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-039 A bench SHALL cover: mthi A=0x12345678, then div B=0 -> Busy high 10 cycles; HI remains 0x12345678 and LO remains 0 afterwards.
REQ-040 A bench SHALL cover: mult started, then at cycle 2 of Busy drive Start with mtlo A=0xDEAD, and with multu -> both ignored; LO receives only the original mult result.
REQ-041 A bench SHALL cover: div started, reset asserted during the 4th Busy cycle -> next cycle Busy=0, HI=LO=0, and no later commit occurs.
REQ-042 A bench SHALL cover: div A=0x80000000, B=0xFFFFFFFF followed by multu A=3, B=5 issued in the first non-Busy cycle -> LO=0x80000000, HI=0, then 5 cycles later HI=0, LO=0x0000000F.
